// File: rtl/mul_controller.sv
// rtl/mul_controller.sv - sequencing FSM for the repeated-addition multiplier datapath
module mul_controller #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             abort,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [WIDTH-1:0] op_data,
   input  logic             res_ack,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] iter_cnt,
   output logic [WIDTH-1:0] dp_data,
   output logic             ldA,
   output logic             ldB,
   output logic             ldP,
   output logic             clrP,
   output logic             decB,
   input  logic             eqz
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GET_B = 2'd1;
   localparam logic [1:0] ACC   = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0] state;
   logic [1:0] state_next;
   logic       lda_c, ldb_c, ldp_c, clrp_c, decb_c;
   logic       cnt_clr, cnt_inc;

   assign dp_data = op_data;

   always_comb begin
      state_next = state;
      op_ready   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      lda_c      = 1'b0;
      ldb_c      = 1'b0;
      ldp_c      = 1'b0;
      clrp_c     = 1'b0;
      decb_c     = 1'b0;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      case (state)
         GET_B: begin
            op_ready = 1'b1;
            busy     = 1'b1;
            if (op_valid) begin
               ldb_c      = 1'b1;
               clrp_c     = 1'b1;
               cnt_clr    = 1'b1;
               state_next = ACC;
            end
         end
         ACC: begin
            busy = 1'b1;
            if (eqz) begin
               state_next = DONE;
            end else begin
               ldp_c   = 1'b1;
               decb_c  = 1'b1;
               cnt_inc = 1'b1;
            end
         end
         DONE: begin
            done = 1'b1;
            if (res_ack) begin
               state_next = IDLE;
            end
         end
         default: begin
            op_ready = 1'b1;
            if (op_valid) begin
               lda_c      = 1'b1;
               state_next = GET_B;
            end
         end
      endcase
      // abort wins over everything; the counter keeps the aborted run's count
      if (abort) begin
         state_next = IDLE;
         lda_c      = 1'b0;
         ldb_c      = 1'b0;
         ldp_c      = 1'b0;
         clrp_c     = 1'b0;
         decb_c     = 1'b0;
         cnt_clr    = 1'b0;
         cnt_inc    = 1'b0;
      end
   end

   // Strobes drop the instant reset asserts, not at the next edge
   assign ldA  = lda_c  & rst_n;
   assign ldB  = ldb_c  & rst_n;
   assign ldP  = ldp_c  & rst_n;
   assign clrP = clrp_c & rst_n;
   assign decB = decb_c & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         iter_cnt <= '0;
      end else begin
         state <= state_next;
         if (cnt_clr) begin
            iter_cnt <= '0;
         end else if (cnt_inc) begin
            iter_cnt <= iter_cnt + WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_mul_controller.sv
// tb/tb_mul_controller.sv - scoreboard bench for mul_controller with a behavioural datapath
module tb_mul_controller;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         abort = 1'b0;
   logic         op_valid = 1'b0;
   logic         res_ack = 1'b0;
   logic [W-1:0] op_data = '0;
   logic         op_ready, busy, done, ldA, ldB, ldP, clrP, decB, eqz;
   logic [W-1:0] iter_cnt, dp_data;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mul_controller #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .abort(abort),
      .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
      .res_ack(res_ack), .busy(busy), .done(done), .iter_cnt(iter_cnt),
      .dp_data(dp_data), .ldA(ldA), .ldB(ldB), .ldP(ldP), .clrP(clrP),
      .decB(decB), .eqz(eqz)
   );

   // Repeated-addition datapath driven by the controller's strobes
   logic [W-1:0] reg_a = '0, reg_b = '0, reg_p = '0;
   always @(posedge clk) begin
      if (ldA) reg_a <= dp_data;
      if (ldB) reg_b <= dp_data;
      else if (decB) reg_b <= reg_b - W'(1);
      if (clrP) reg_p <= '0;
      else if (ldP) reg_p <= reg_p + reg_a;
   end
   assign eqz = (reg_b == '0);

   typedef struct { logic [W-1:0] a; logic [W-1:0] b; } run_t;
   run_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every done rise is checked against the oldest expected run
   int           ncyc = 0, nb = 0, ldp_cnt = 0;
   logic         done_q = 1'b0;
   run_t         cur;
   logic [W-1:0] prod;
   initial begin
      forever begin
         @(negedge clk);
         ncyc++;
         if (ldP || decB) chk("ldp_decb_pair", ldP, decB);
         if (abort) chk("strobes_in_abort", {ldA, ldB, ldP, clrP, decB}, 0);
         if (ldB && clrP) begin
            nb = ncyc;
            ldp_cnt = 0;
         end else if (ldP) begin
            ldp_cnt++;
         end
         if (done && !done_q) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               cur  = sb.pop_front();
               prod = cur.a * cur.b;
               chk("product", reg_p, prod);
               chk("iter_cnt", iter_cnt, cur.b);
               chk("ldp_count", ldp_cnt, cur.b);
               chk("done_latency", ncyc - nb, int'(cur.b) + 2);
            end
         end
         done_q = done;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Called just after a rising edge; returns just after the accepting edge
   task automatic send_beat(input logic [W-1:0] d, input bit is_a, output int waits);
      waits = 0;
      op_valid = 1'b1;
      op_data  = d;
      @(negedge clk);
      while (!op_ready && waits < 50) begin
         @(negedge clk);
         waits++;
      end
      chk("beat_ready", op_ready, 1);
      chk("ldA_strobe", ldA, is_a);
      chk("ldB_strobe", ldB, !is_a);
      chk("clrP_strobe", clrP, !is_a);
      chk("dp_data", dp_data, d);
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      op_data  = W'($urandom);
   endtask

   task automatic finish_run(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
      int n = 0;
      logic [W-1:0] p = a * b;
      @(negedge clk);
      while (!done && n < int'(b) + 20) begin
         @(negedge clk);
         n++;
      end
      chk("done_reached", done, 1);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_done", done, 1);
         chk("hold_ready", op_ready, 0);
         chk("hold_iter", iter_cnt, b);
         chk("hold_p", reg_p, p);
      end
      res_ack = 1'b1;
      @(posedge clk);
      #1;
      res_ack = 1'b0;
      chk("ack_done_low", done, 0);
      chk("ack_ready", op_ready, 1);
      chk("ack_busy", busy, 0);
   endtask

   task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input int gap,
                      input int hold, input bit ack_early);
      int   w;
      run_t r;
      send_beat(a, 1'b1, w);
      for (int i = 0; i < gap; i++) begin
         @(negedge clk);
         chk("gap_ready", op_ready, 1);
         chk("gap_busy", busy, 1);
         @(posedge clk);
         #1;
      end
      r.a = a;
      r.b = b;
      sb.push_back(r);
      send_beat(b, 1'b0, w);
      if (ack_early) begin
         res_ack = 1'b1;
         repeat (2) begin
            @(posedge clk);
            #1;
         end
         res_ack = 1'b0;
      end
      finish_run(a, b, hold);
   endtask

   initial begin
      int   w;
      run_t r;
      rst_n    = 1'b0;
      op_valid = 1'b1;
      op_data  = 16'hA5A5;
      #12;
      chk("rst_strobes", {ldA, ldB, ldP, clrP, decB}, 0);
      chk("rst_ready", op_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_iter", iter_cnt, 0);
      chk("rst_dp_data", dp_data, 16'hA5A5);
      op_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      run(16'd3, 16'd5, 0, 0, 1'b0);
      run(16'd1234, 16'd0, 0, 1, 1'b0);
      run(16'd0, 16'd7, 4, 0, 1'b0);

      // abort in the 4th ACC cycle of a 2x10 run
      send_beat(16'd2, 1'b1, w);
      send_beat(16'd10, 1'b0, w);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      abort = 1'b1;
      @(negedge clk);
      chk("abort_ldP", ldP, 0);
      chk("abort_decB", decB, 0);
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_ready", op_ready, 1);
      chk("abort_iter", iter_cnt, 3);
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_done", done, 0);
      end
      @(posedge clk);
      #1;
      run(16'd4, 16'd4, 0, 0, 1'b0);

      // asynchronous reset in the middle of ACC
      send_beat(16'd5, 1'b1, w);
      send_beat(16'd9, 1'b0, w);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset_ldP", ldP, 0);
      chk("areset_decB", decB, 0);
      chk("areset_iter", iter_cnt, 0);
      chk("areset_busy", busy, 0);
      chk("areset_ready", op_ready, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run(16'd6, 16'd6, 0, 0, 1'b0);

      // done held, early ack ignored, next A accepted right after ack
      run(16'd9, 16'd3, 0, 5, 1'b1);
      send_beat(16'd7, 1'b1, w);
      chk("a_after_ack_waits", w, 0);
      r.a = 16'd7;
      r.b = 16'd2;
      sb.push_back(r);
      send_beat(16'd2, 1'b0, w);
      finish_run(16'd7, 16'd2, 0);

      for (int i = 0; i < 8; i++) begin
         run(W'($urandom), W'($urandom_range(0, 24)), $urandom_range(0, 3),
             $urandom_range(0, 3), 1'b0);
      end
      run(W'($urandom), 16'd200, 1, 0, 1'b0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mul_controller.md
# mul_controller

Control unit for the repeated-addition multiplier datapath. It accepts two operands over a valid/ready bus: multiplicand A first, then multiplier B. It forwards each operand onto the datapath input bus and sequences the ldA, ldB, clrP, ldP and decB strobes until the datapath's eqz flag reports B exhausted. It then holds a done indication until the consumer acknowledges the product held in the datapath's P register.

## Interface
- WIDTH, 16, operand, bus and iteration-counter width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- abort  in  1  synchronous abort; returns to IDLE
- op_valid  in  1  operand beat valid
- op_ready  out  1  controller can accept an operand beat
- op_data  in  WIDTH  operand value: A on first beat, B on second
- res_ack  in  1  consumer has taken the product
- busy  out  1  multiplication in progress
- done  out  1  product valid in datapath P
- iter_cnt  out  WIDTH  number of ldP strobes in the current or last run
- dp_data  out  WIDTH  datapath data_in bus
- ldA, ldB, ldP, clrP, decB  out  1 each  datapath control strobes
- eqz  in  1  datapath flag: B register == 0 (combinational from B)

## Operation
- dp_data = op_data combinationally, in every state.
- Strobes are Mealy outputs from the current state and inputs. They are zero whenever abort=1, and zero in any state not listed below.
- IDLE:
  - Outputs: op_ready=1, busy=0, done=0.
  - On op_valid: ldA=1; next state GET_B.
- GET_B:
  - Outputs: op_ready=1, busy=1.
  - On op_valid: ldB=1 and clrP=1 in the same cycle; iter_cnt cleared to 0; next state ACC.
  - Otherwise: stay in GET_B; A is retained.
- ACC:
  - Outputs: op_ready=0, busy=1.
  - If eqz=1: no strobes; next state DONE.
  - Else: ldP=1, decB=1, iter_cnt+1; stay in ACC.
- DONE:
  - Outputs: op_ready=0, busy=0, done=1. No strobes, so P stays stable.
  - On res_ack: next state IDLE.
  - res_ack is ignored in every other state.
- abort=1 in any state:
  - Next state IDLE; no strobes that cycle; iter_cnt holds.
  - abort has priority over op_valid, eqz and res_ack.
- Arithmetic:
  - iter_cnt wraps modulo 2^WIDTH. It cannot wrap in practice, since B ≤ 2^WIDTH−1.
  - At done, iter_cnt = B.
  - Product overflow is the datapath's concern; the controller does not detect it.
- State encoding: 2-bit, IDLE=0, GET_B=1, ACC=2, DONE=3. Unreachable codes decode as IDLE.

## Timing
- Reset (asynchronous assert, synchronous deassert by the integrator):
  - state=IDLE, iter_cnt=0, done=0, busy=0, op_ready=1.
  - All strobes 0; dp_data follows op_data.
- Reset mid-operation returns to IDLE. Datapath contents are then undefined; the controller does not clear them.
- A beat transfers on a rising edge with op_valid=1 and op_ready=1.
- Let the B beat transfer at edge E.
  - ACC occupies cycles E+1 … E+B+1.
  - ldP/decB are high for exactly B cycles.
  - done rises after edge E+B+1, i.e. B+1 cycles after B is accepted.
- B=0: first ACC cycle sees eqz=1; done after 1 cycle; P=0; iter_cnt=0.
- done is level: it stays high until the edge at which res_ack=1 is sampled, and falls the following cycle.
- Minimum turnaround between products is 1 cycle. A new A can be accepted in the first IDLE cycle after ack.
- op_valid may drop between beats for any number of cycles. No timeout applies.

## Test plan
- A=3, B=5, back-to-back beats:
  - ldA on beat 1; ldB+clrP on beat 2.
  - 5 consecutive ldP/decB cycles.
  - done high 6 cycles after the B edge; iter_cnt=5; datapath P=15.
- A=1234, B=0:
  - No ldP; done 1 cycle after the B edge.
  - iter_cnt=0; P=0.
- A=0, B=7, with op_valid low for 4 cycles between beats:
  - Controller waits in GET_B with op_ready=1.
  - 7 ldP cycles; P=0; iter_cnt=7.
- A=2, B=10, abort pulsed in the 4th ACC cycle:
  - No strobe in the abort cycle; IDLE next cycle.
  - busy=0; done never rises; iter_cnt=3.
  - A fresh 4×4 run afterwards yields P=16.
- rst_n low mid-ACC, asynchronously:
  - Strobes drop immediately; state IDLE; iter_cnt=0.
  - The next 6×6 run yields P=36.
- done held for 5 cycles without res_ack:
  - done, P and iter_cnt stay stable; op_ready=0.
  - res_ack before done (during ACC) has no effect.
  - After ack, A is accepted in the next cycle.
